// File: rtl/serv_mem_responder.sv
// rtl/serv_mem_responder.sv - ibus/dbus target for serv_top with shared word memory and programmable ack latency
// Optional feature macro: SERV_RESP_STALL_EN (adds i_stall, freezes WAIT counters of both buses)

module serv_mem_responder_port #(
    parameter int LAT = 0
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_cyc,
    input  logic i_stall,
    output logic o_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    localparam logic [3:0] LAT_W = 4'(LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: count down LAT wait cycles, ack once, then a dead cycle before re-arming
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_cyc) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LAT_W;
                end
            end
            S_WAIT: begin
                if (!i_cyc) begin
                    w_state_nxt = S_IDLE;
                end else if (i_stall) begin
                    w_state_nxt = S_WAIT;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_ack = (r_state == S_ACK);

endmodule

module serv_mem_responder #(
    parameter int AW       = 10,
    parameter int IBUS_LAT = 2,
    parameter int DBUS_LAT = 1
) (
    input  logic          clk,
    input  logic          i_rst,
`ifdef SERV_RESP_STALL_EN
    input  logic          i_stall,
`endif
    input  logic [31:0]   i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [31:0]   i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_adr,
    input  logic [31:0]   i_ld_dat
);

    logic [31:0]   r_mem [2**AW];
    logic [AW-1:0] w_ibus_idx;
    logic [AW-1:0] w_dbus_idx;
    logic          w_ibus_ack;
    logic          w_dbus_ack;
    logic          w_stall;
    logic          w_unused_bits;

`ifdef SERV_RESP_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Byte-address LSBs and bits above the memory depth are dropped, so addresses wrap
    assign w_ibus_idx    = i_ibus_adr[AW+1:2];
    assign w_dbus_idx    = i_dbus_adr[AW+1:2];
    assign w_unused_bits = ^{i_ibus_adr[31:AW+2], i_ibus_adr[1:0],
                             i_dbus_adr[31:AW+2], i_dbus_adr[1:0]};

    serv_mem_responder_port #(
        .LAT (IBUS_LAT)
    ) u_ibus_port (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_cyc   (i_ibus_cyc),
        .i_stall (w_stall),
        .o_ack   (w_ibus_ack)
    );

    serv_mem_responder_port #(
        .LAT (DBUS_LAT)
    ) u_dbus_port (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_cyc   (i_dbus_cyc),
        .i_stall (w_stall),
        .o_ack   (w_dbus_ack)
    );

    assign o_ibus_ack = w_ibus_ack;
    assign o_dbus_ack = w_dbus_ack;

    // Asynchronous read during the ack cycle gives read-before-write against the same edge
    assign o_ibus_rdt = w_ibus_ack ? r_mem[w_ibus_idx] : 32'd0;
    assign o_dbus_rdt = (w_dbus_ack && !i_dbus_we) ? r_mem[w_dbus_idx] : 32'd0;

    // Backdoor word write first, then selected dbus store bytes override it on the same edge
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_adr] <= i_ld_dat;
        end
        if (w_dbus_ack && i_dbus_we && !i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (i_dbus_sel[b]) begin
                    r_mem[w_dbus_idx][8*b +: 8] <= i_dbus_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_serv_mem_responder.sv
// tb/tb_serv_mem_responder.sv - self-checking bench for serv_mem_responder

module tb_serv_mem_responder;

    localparam int AW = 10;
    localparam int IL = 2;
    localparam int DL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ibus_adr;
    logic          ibus_cyc;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic [31:0]   dbus_adr;
    logic [31:0]   dbus_dat;
    logic [3:0]    dbus_sel;
    logic          dbus_we;
    logic          dbus_cyc;
    logic [31:0]   dbus_rdt;
    logic          dbus_ack;
    logic          ld_en;
    logic [AW-1:0] ld_adr;
    logic [31:0]   ld_dat;
`ifdef SERV_RESP_STALL_EN
    logic          stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [1024];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    serv_mem_responder #(
        .AW       (AW),
        .IBUS_LAT (IL),
        .DBUS_LAT (DL)
    ) dut (
        .clk        (clk),
        .i_rst      (rst),
`ifdef SERV_RESP_STALL_EN
        .i_stall    (stall),
`endif
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .i_ld_en    (ld_en),
        .i_ld_adr   (ld_adr),
        .i_ld_dat   (ld_dat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    task automatic backdoor(input int w, input logic [31:0] d);
        ld_en  = 1'b1;
        ld_adr = AW'(w);
        ld_dat = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        model[w] = d;
    endtask

    task automatic ibus_txn(input logic [31:0] adr, input bit use_model,
                            input logic [31:0] exp_c, input string name);
        int          n;
        bit          got;
        logic [31:0] exp;
        ibus_adr = adr;
        ibus_cyc = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ibus_ack) got = 1'b1;
            else begin
                chk({name, "_rdt_idle"}, ibus_rdt, 32'd0);
                @(posedge clk);
                n++;
            end
        end
        chk({name, "_ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "_latency"}, 32'(n), 32'(IL + 2));
            exp = use_model ? model[widx(adr)] : exp_c;
            chk({name, "_rdt"}, ibus_rdt, exp);
        end
        @(posedge clk);
        #1;
        ibus_cyc = 1'b0;
        @(negedge clk);
        chk({name, "_hold_ack"}, 32'(ibus_ack), 32'd0);
        chk({name, "_hold_rdt"}, ibus_rdt, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic dbus_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input bit use_model,
                            input logic [31:0] exp_c, input string name);
        int          n;
        bit          got;
        logic [31:0] exp;
        dbus_adr = adr;
        dbus_we  = we;
        dbus_sel = sel;
        dbus_dat = dat;
        dbus_cyc = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (dbus_ack) got = 1'b1;
            else begin
                chk({name, "_rdt_idle"}, dbus_rdt, 32'd0);
                @(posedge clk);
                n++;
            end
        end
        chk({name, "_ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "_latency"}, 32'(n), 32'(DL + 2));
            exp = we ? 32'd0 : (use_model ? model[widx(adr)] : exp_c);
            chk({name, "_rdt"}, dbus_rdt, exp);
        end
        @(posedge clk);
        if (got && we) model[widx(adr)] = merge(model[widx(adr)], dat, sel);
        #1;
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        @(negedge clk);
        chk({name, "_hold_ack"}, 32'(dbus_ack), 32'd0);
        chk({name, "_hold_rdt"}, dbus_rdt, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int acks;
        int n;
        bit got;

        vt[0] = '{1'b1, 32'h0000_0040, 4'b0101, 32'hAABB_CCDD, 32'h0};
        vt[1] = '{1'b0, 32'h0000_0040, 4'b0000, 32'h0,         32'h11BB_33DD};
        vt[2] = '{1'b1, 32'h0000_0044, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        vt[3] = '{1'b0, 32'h0000_0044, 4'b0000, 32'h0,         32'hC0DE_0011};
        vt[4] = '{1'b1, 32'h0000_0048, 4'b1000, 32'h1234_5678, 32'h0};
        vt[5] = '{1'b0, 32'h0000_0048, 4'b0000, 32'h0,         32'h12DE_0012};
        vt[6] = '{1'b0, 32'h0000_1004, 4'b0000, 32'h0,         32'hC0DE_0001};
        vt[7] = '{1'b1, 32'h0000_1007, 4'b0010, 32'h0000_AB00, 32'h0};
        vt[8] = '{1'b0, 32'h0000_0004, 4'b0000, 32'h0,         32'hC0DE_AB01};

        rst = 1'b1;
        ibus_adr = 32'd0; ibus_cyc = 1'b0;
        dbus_adr = 32'd0; dbus_dat = 32'd0; dbus_sel = 4'd0; dbus_we = 1'b0; dbus_cyc = 1'b0;
        ld_en = 1'b0; ld_adr = '0; ld_dat = 32'd0;
`ifdef SERV_RESP_STALL_EN
        stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ibus_ack", 32'(ibus_ack), 32'd0);
        chk("reset_dbus_ack", 32'(dbus_ack), 32'd0);
        chk("reset_ibus_rdt", ibus_rdt, 32'd0);
        chk("reset_dbus_rdt", dbus_rdt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 64; i++) backdoor(i, 32'hC0DE_0000 | 32'(i));
        backdoor(2, 32'h0020_8463);
        backdoor(16, 32'h1122_3344);
        backdoor(32, 32'h0);

        ibus_txn(32'h8, 1'b0, 32'h0020_8463, "fetch_beq");

        for (int i = 0; i < 9; i++)
            dbus_txn(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, 1'b0, vt[i].exp,
                     $sformatf("vec%0d", i));

        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        @(posedge clk);
        #1;
        ibus_cyc = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ibus_ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        @(posedge clk);
        #1;
        ibus_txn(32'h0, 1'b0, 32'hC0DE_0000, "after_abort");

        fork
            ibus_txn(32'h80, 1'b0, 32'h0, "rbw_ibus");
            begin
                repeat (IL - DL) @(posedge clk);
                #1;
                dbus_txn(1'b1, 32'h80, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, "rbw_dbus");
            end
        join
        ibus_txn(32'h80, 1'b0, 32'hFFFF_FFFF, "rbw_after");

        dbus_adr = 32'hC0; dbus_we = 1'b1; dbus_sel = 4'b0011; dbus_dat = 32'h1234_ABCD;
        dbus_cyc = 1'b1;
        repeat (DL + 2) @(posedge clk);
        #1;
        ld_en = 1'b1; ld_adr = AW'(48); ld_dat = 32'h5566_7788;
        @(negedge clk);
        chk("ld_store_ack", 32'(dbus_ack), 32'd1);
        @(posedge clk);
        #1;
        ld_en = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
        @(posedge clk);
        #1;
        model[48] = 32'h5566_ABCD;
        dbus_txn(1'b0, 32'hC0, 4'h0, 32'h0, 1'b0, 32'h5566_ABCD, "ld_vs_store");

        dbus_adr = 32'hC8; dbus_we = 1'b1; dbus_sel = 4'hF; dbus_dat = 32'hDEAD_BEEF;
        dbus_cyc = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
        @(negedge clk);
        chk("rst_wait_ack", 32'(dbus_ack), 32'd0);
        chk("rst_wait_rdt", dbus_rdt, 32'd0);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (dbus_ack) acks++;
        end
        chk("rst_wait_no_ack", 32'(acks), 32'd0);
        @(posedge clk);
        #1;
        dbus_txn(1'b0, 32'hC8, 4'h0, 32'h0, 1'b0, 32'hC0DE_0032, "rst_wait_mem");

`ifdef SERV_RESP_STALL_EN
        ibus_adr = 32'h8;
        ibus_cyc = 1'b1;
        n = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        n = 1;
        stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n = 6;
        stall = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ibus_ack) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk("stall_latency", 32'(n), 32'(IL + 2 + 5));
        chk("stall_rdt", ibus_rdt, 32'h0020_8463);
        @(posedge clk);
        #1;
        ibus_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    ibus_txn(($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
                             | 32'($urandom_range(0, 3)), 1'b1, 32'h0, "rnd_ibus");
                end
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    dbus_txn(1'($urandom_range(0, 1)),
                             ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
                             | 32'($urandom_range(0, 3)),
                             4'($urandom), $urandom, 1'b1, 32'h0, "rnd_dbus");
                end
            end
        join

        for (int w = 0; w < 64; w += 9)
            dbus_txn(1'b0, 32'(w) << 2, 4'h0, 32'h0, 1'b1, 32'h0, "final_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_mem_responder.md
Name: serv_mem_responder

Overview:
- Bus-side responder for serv_top: acts as target on both the instruction bus (ibus) and the data bus (dbus).
- Serves ibus fetches and dbus loads/stores from a shared word-addressed memory, with per-bus programmable ack latency.
- A backdoor load port preloads instruction streams (e.g. BEQ sequences) for simulation and formal harnesses.
- Guarantees the bus contract: ack never asserted while cyc is low, and exactly one single-cycle ack per request.

Parameters:
- AW, 10, log2 of memory depth in 32-bit words (1024 words).
- IBUS_LAT, 2, extra wait cycles before ibus ack (0..15).
- DBUS_LAT, 1, extra wait cycles before dbus ack (0..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ibus_adr  in  32  fetch byte address from core; stable while i_ibus_cyc=1.
- i_ibus_cyc  in  1  fetch request.
- o_ibus_rdt  out  32  fetched instruction word.
- o_ibus_ack  out  1  fetch ack, single-cycle pulse.
- i_dbus_adr  in  32  data byte address.
- i_dbus_dat  in  32  store data.
- i_dbus_sel  in  4  byte enables (bit n = byte n).
- i_dbus_we  in  1  1 = store, 0 = load.
- i_dbus_cyc  in  1  data request.
- o_dbus_rdt  out  32  load data.
- o_dbus_ack  out  1  data ack, single-cycle pulse.
- i_ld_en  in  1  backdoor write strobe.
- i_ld_adr  in  AW  backdoor word index.
- i_ld_dat  in  32  backdoor write data (full word).

Behaviour:
- Reset: o_ibus_ack=0, o_dbus_ack=0, o_ibus_rdt=0, o_dbus_rdt=0, both FSMs IDLE, both counters 0. Memory array is not reset.
- Addressing: word index = adr[AW+1:2]. adr[1:0] and upper bits ignored, so out-of-range addresses wrap modulo depth.
- Each bus has an independent FSM: IDLE, WAIT, ACK, HOLD.
  - IDLE: cyc=1 -> load counter with LAT, go WAIT. cyc=0 -> stay.
  - WAIT: cyc=0 -> abort to IDLE, no ack, no memory side effect. Counter=0 -> go ACK. Otherwise decrement.
  - ACK: ack=1 for exactly this cycle; rdt = mem[index] read in this cycle. Next state HOLD.
  - HOLD: ack=0; ignore cyc for one cycle, then go IDLE. Prevents a double ack if the core drops cyc late.
- Latency: if cyc first sampled high in IDLE at edge t, ack is high in the cycle after edge t+1+LAT. With LAT=0, ack comes 2 cycles after cyc rises.
- rdt is valid only while ack=1 and is 0 otherwise. Stores (we=1) return rdt=0.
- dbus store: committed on the ACK-cycle edge; only bytes with sel[n]=1 are written. sel=0000 still acks with no write.
- Write ordering on the same edge: backdoor load is applied first, then the dbus store bytes override it (dbus wins per selected byte).
- Read vs write, same word, same cycle: read returns the pre-edge value (read-before-write) on both buses.
- ibus and dbus run fully concurrently; both may ack in the same cycle.
- Reset mid-transaction: FSM returns to IDLE next edge, no ack, no pending store committed.
- Invariant: ack=1 implies cyc=1 in the same cycle, provided the core holds cyc until ack.

Optional Feature:
- Macro SERV_RESP_STALL_EN.
- Defined:
  - Adds input port i_stall (1 bit).
  - While i_stall=1, the WAIT counters of both buses hold (no decrement, no WAIT->ACK transition).
  - ACK and HOLD states are unaffected.
  - The cyc=0 abort still applies during stall.
  - Lets a formal tool inject arbitrary back-pressure.
- Undefined: no i_stall port; counters always run.

Test Plan:
- Preload mem[2]=0x00208463 (BEQ x1,x2,+8) via i_ld_en; ibus fetch adr=0x8 with IBUS_LAT=2, cyc rising at cycle 10 -> ack=1 and rdt=0x00208463 at cycle 14 only; rdt=0 at cycles 13 and 15.
- dbus store adr=0x40, dat=0xAABBCCDD, sel=0101 over prior word 0x11223344 -> ack once; then load adr=0x40 returns 0x11BB33DD.
- ibus cyc asserted and dropped after 1 cycle with IBUS_LAT=3 -> no ack ever; next request at adr=0x0 acks normally after 2+3 cycles.
- ibus fetch and dbus store to the same word on the same cycle, old=0x0, new=0xFFFFFFFF, sel=1111 -> ibus rdt=0x0; next fetch returns 0xFFFFFFFF.
- Address 0x1004 with AW=10 -> wraps to word 1; reads mem[1].
- i_rst asserted during WAIT of a dbus store -> no ack, memory unchanged, outputs 0 next cycle. With SERV_RESP_STALL_EN, i_stall high 5 cycles during WAIT delays ack by exactly 5 cycles.
